// File: rtl/aes128_iter.sv
// Iterative AES-128 encryption core: UNROLL rounds per clock, with the round keys
// expanded on the fly alongside the state. Valid/ready handshakes on input and output.
module aes128_iter #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
      $error("aes128_iter: UNROLL must be 1, 2, 5 or 10");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   localparam logic [3:0] STEP = 4'(UNROLL);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte b lives at bit offset 8*(255-b), i.e. {~b, 3'b000}.
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = {sub_byte(k[23:16]), sub_byte(k[15:8]), sub_byte(k[7:0]), sub_byte(k[31:24])}
           ^ {rc, 24'h000000};
      w0 = k[127:96] ^ t;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Byte k of the block is row k%4, column k/4; ShiftRows rotates row r left by r.
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      res = 128'h0;
      for (int k = 0; k < 16; k++) b[k] = sub_byte(s[127 - 8 * k -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[4 * c + r] = b[4 * ((c + r) & 3) + r];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4 * c];
         a1 = t[4 * c + 1];
         a2 = t[4 * c + 2];
         a3 = t[4 * c + 3];
         if (last) begin
            res[127 - 32 * c -: 32] = {a0, a1, a2, a3};
         end else begin
            res[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
         end
      end
      return res ^ rk;
   endfunction

   state_e       state_q, state_d;
   logic [127:0] st_q, st_d, key_q, key_d, out_data_q, out_data_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] chain_st_s, chain_key_s;
   logic         last_s;

   // Round datapath: UNROLL key-expansion steps and rounds chained in one cycle.
   always_comb begin
      chain_st_s  = st_q;
      chain_key_s = key_q;
      for (int u = 0; u < UNROLL; u++) begin
         chain_key_s = key_step(chain_key_s, rcon(rnd_q + 4'(u + 1)));
         chain_st_s  = enc_round(chain_st_s, chain_key_s, (rnd_q + 4'(u + 1)) == 4'd10);
      end
      last_s = (rnd_q + STEP) == 4'd10;
   end

   // Next-state and next-register values for the IDLE/RUN/DONE sequence.
   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      key_d      = key_q;
      rnd_d      = rnd_q;
      out_data_d = out_data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_data ^ in_key;
               key_d   = in_key;
               rnd_d   = 4'd0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            st_d  = chain_st_s;
            key_d = chain_key_s;
            rnd_d = rnd_q + STEP;
            if (last_s) begin
               out_data_d = chain_st_s;
               state_d    = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == DONE);
   end

   // State, datapath and output registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         st_q        <= 128'h0;
         key_q       <= 128'h0;
         rnd_q       <= 4'd0;
         out_data_q  <= 128'h0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         key_q       <= key_d;
         rnd_q       <= rnd_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes128_iter.sv
// Directed and random checks of aes128_iter: four instances cover every unroll factor
// on the App. B vector; the UNROLL=1 instance carries the handshake and regression tests.
module tb_aes128_iter;

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk = 1'b0;
   logic         rst, in_valid, out_ready;
   logic [127:0] in_data, in_key;
   logic [3:0]   in_ready_s, out_valid_s;
   logic [127:0] out_data_s [4];

   int n_checks = 0;
   int n_err    = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] q [$];
   logic [127:0] got [4];
   int           lat [4];
   int           tout [4];
   logic [127:0] od, pt, key, expv, sv [2];
   bit           acc, hs, seen;
   int           nout, vi, cyc, sent, recv;
   logic [7:0]   inv, x;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
      aes128_iter #(.UNROLL(U)) dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid),
         .in_ready (in_ready_s[g]),
         .in_data  (in_data),
         .in_key   (in_key),
         .out_valid(out_valid_s[g]),
         .out_ready(out_ready),
         .out_data (out_data_s[g])
      );
   end

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   function automatic int nrounds(input int g);
      case (g)
         0:       return 10;
         1:       return 5;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Reference cipher: full key schedule up front, generic MixColumns matrix.
   function automatic logic [127:0] aes_model(input logic [127:0] p_in, input logic [127:0] k_in);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k_in[127 - 32 * i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i - 1];
         if (i % 4 == 0) begin
            tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i - 4] ^ tmp;
      end
      for (int k = 0; k < 16; k++) s[k] = p_in[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rnd < 10)
                  s[4 * c + r] = gmul(t[4 * c + r], 8'h02) ^ gmul(t[4 * c + (r + 1) % 4], 8'h03)
                                 ^ t[4 * c + (r + 2) % 4] ^ t[4 * c + (r + 3) % 4];
               else
                  s[4 * c + r] = t[4 * c + r];
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4 * rnd + k / 4][31 - 8 * (k % 4) -: 8];
      end
      for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one block to the UNROLL=1 instance, then check latency and ciphertext.
   task automatic run_block(input string tag, input logic [127:0] p_in, input logic [127:0] k_in,
                            input logic [127:0] exp);
      bit a;
      int l;
      a        = 1'b0;
      in_data  = p_in;
      in_key   = k_in;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !a; i++) begin
         a = in_ready_s[0];
         step();
      end
      in_valid = 1'b0;
      chk({tag, "_accept"}, 128'(a), 128'd1);
      l = 0;
      while (!out_valid_s[0] && l < 30) begin
         step();
         l++;
      end
      chk({tag, "_latency"}, 128'(l), 128'd10);
      chk({tag, "_data"}, out_data_s[0], exp);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = 128'h0;
      in_key    = 128'h0;
      for (int v = 0; v < 256; v++) begin
         x   = 8'(v);
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, x);
         sbox_m[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                     ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      // Reset state
      step();
      step();
      chk("rst_out_valid", 128'(out_valid_s), 128'd0);
      chk("rst_in_ready_during_rst", 128'(in_ready_s), 128'd0);
      for (int g = 0; g < 4; g++) chk($sformatf("rst_out_data_u%0d", g), out_data_s[g], 128'h0);
      rst = 1'b0;
      step();
      chk("rst_in_ready_after", 128'(in_ready_s), 128'hf);

      // App. B on every unroll factor, latency N after the shared accept edge
      in_data  = PT_B;
      in_key   = KEY_B;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 4; g++) lat[g] = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         for (int g = 0; g < 4; g++)
            if (out_valid_s[g] && lat[g] == 0) begin
               lat[g] = c;
               got[g] = out_data_s[g];
            end
      end
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("appB_u%0d_latency", g), 128'(lat[g]), 128'(nrounds(g)));
         chk($sformatf("appB_u%0d_data", g), got[g], CT_B);
      end

      // App. C.1
      run_block("appC", PT_C, KEY_C, CT_C);
      step();

      // Backpressure: output held, inputs toggled, no new accept
      out_ready = 1'b0;
      run_block("bp", PT_B, KEY_B, CT_B);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         in_key   = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("bp_out_valid", 128'(out_valid_s[0]), 128'd1);
         chk("bp_out_data", out_data_s[0], CT_B);
         chk("bp_in_ready", 128'(in_ready_s[0]), 128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_release_in_ready", 128'(in_ready_s[0]), 128'd1);
      chk("bp_release_out_valid", 128'(out_valid_s[0]), 128'd0);

      // Streaming: both vectors with in_valid held, outputs spaced N+2 apart
      sv[0]    = PT_B;
      sv[1]    = PT_C;
      vi       = 0;
      nout     = 0;
      in_data  = PT_B;
      in_key   = KEY_B;
      in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         acc = in_valid && in_ready_s[0];
         if (out_valid_s[0]) begin
            if (nout < 4) begin
               got[nout]  = out_data_s[0];
               tout[nout] = c;
            end
            nout++;
         end
         step();
         if (acc) begin
            vi++;
            if (vi < 2) begin
               in_data = sv[vi];
               in_key  = KEY_C;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("stream_count", 128'(nout), 128'd2);
      chk("stream_first", got[0], CT_B);
      chk("stream_second", got[1], CT_C);
      chk("stream_spacing", 128'(tout[1] - tout[0]), 128'd12);

      // Reset mid-RUN discards the block
      in_data  = PT_B;
      in_key   = KEY_B;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = in_ready_s[0];
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      chk("midrst_in_ready_low", 128'(in_ready_s[0]), 128'd0);
      step();
      rst = 1'b0;
      chk("midrst_out_valid", 128'(out_valid_s[0]), 128'd0);
      chk("midrst_out_data", out_data_s[0], 128'h0);
      step();
      chk("midrst_in_ready", 128'(in_ready_s[0]), 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid_s[0]) seen = 1'b1;
         step();
      end
      chk("midrst_no_output", 128'(seen), 128'd0);
      run_block("postrst", PT_C, KEY_C, CT_C);
      step();

      // Random regression against the reference model with random stalls
      sent     = 0;
      recv     = 0;
      cyc      = 0;
      in_valid = 1'b0;
      while (recv < 1000 && cyc < 60000) begin
         if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
            pt       = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            in_data  = pt;
            in_key   = key;
            in_valid = 1'b1;
            q.push_back(aes_model(pt, key));
            sent++;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc       = in_valid && in_ready_s[0];
         hs        = out_valid_s[0] && out_ready;
         od        = out_data_s[0];
         step();
         cyc++;
         if (acc) in_valid = 1'b0;
         if (hs) begin
            n_checks++;
            assert (q.size() > 0)
            else begin
               n_err++;
               $error("FAIL rand_dup observed=extra block %h expected=none", od);
            end
            if (q.size() > 0) begin
               expv = q.pop_front();
               chk("rand_data", od, expv);
               recv++;
            end
         end
      end
      chk("rand_received", 128'(recv), 128'd1000);
      chk("rand_pending", 128'(q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
